// File: rtl/fewcore_pkg.sv
// Shared opcode/funct3 constants and the data-memory stage state type.
package fewcore_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/ack bus between the mem_access stage and data memory.
interface mem_access_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane steering: store data/enables, load formatting and
// the misaligned/illegal-funct3 check.
module mem_align
    import fewcore_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data,
    output logic        err
);

    logic [31:0] lane_data;

    always_comb begin
        wdata = '0;
        be    = '0;
        err   = 1'b0;
        case (funct3)
            F3_B: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << offset;
            end
            F3_H: begin
                wdata = {2{store_data[15:0]}};
                be    = 4'b0011 << offset;
                err   = offset[0];
            end
            F3_W: begin
                wdata = store_data;
                be    = '1;
                err   = |offset;
            end
            // Unsigned variants exist for loads only
            F3_BU:   err = is_store;
            F3_HU:   err = is_store | offset[0];
            default: err = 1'b1;
        endcase
        if (is_load) begin
            be = '1;
        end
        if (!is_load && !is_store) begin
            err = 1'b0;
        end
    end

    assign lane_data = rdata >> {ld_offset, 3'b000};

    always_comb begin
        load_data = rdata;
        case (ld_funct3)
            F3_B, F3_BU: load_data = {lane_data[7:0], 24'h0};
            F3_H, F3_HU: load_data = {lane_data[15:0], 16'h0};
            default:     load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Data-memory access stage: req/ack handshake FSM that stalls the pipeline
// while an access is outstanding and returns left-aligned load data.
module mem_access
    import fewcore_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [11:0]     operation,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            stall,
    output logic [31:0]     mem_data,
    output logic            done,
    output logic            mem_err,
    mem_access_if.master    dmem
);

    mem_state_t  state_q, state_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store, mem_op;
    logic        unused_op_bits;

    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q, mem_data_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic [31:0] wdata_c, load_data_c;
    logic [3:0]  be_c;
    logic        err_c;
    logic        issue;

    assign opcode         = operation[6:0];
    assign funct3         = operation[9:7];
    assign unused_op_bits = ^operation[11:10];
    assign is_load        = (opcode == OP_LOAD);
    assign is_store       = (opcode == OP_STORE);
    assign mem_op         = is_load | is_store;

    // Load formatting uses the latched funct3/offset, since dmem_addr has its low bits cleared
    mem_align u_align (
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .offset     (addr[1:0]),
        .store_data (store_data),
        .ld_funct3  (f3_q),
        .ld_offset  (off_q),
        .rdata      (dmem.dmem_rdata),
        .wdata      (wdata_c),
        .be         (be_c),
        .load_data  (load_data_c),
        .err        (err_c)
    );

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        done    = 1'b0;
        mem_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in && mem_op) begin
                    if (err_c) begin
                        mem_err = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem.dmem_ack) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue = (state_q == IDLE) && (state_d == BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            mem_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                req_q   <= 1'b1;
                we_q    <= is_store;
                addr_q  <= {addr[31:2], 2'b00};
                be_q    <= be_c;
                wdata_q <= wdata_c;
                f3_q    <= funct3;
                off_q   <= addr[1:0];
            end
            if ((state_q == BUSY) && dmem.dmem_ack) begin
                req_q <= 1'b0;
                if (!we_q) begin
                    mem_data_q <= load_data_c;
                end
            end
        end
    end

    assign mem_data        = mem_data_q;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: random load/store stream against a
// byte-level memory reference model, plus reset-during-access scenario.
module tb_mem_access;
    import fewcore_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [11:0] operation;
    logic [31:0] addr, store_data;
    logic        stall, done, mem_err;
    logic [31:0] mem_data;

    mem_access_if dmem_bus ();

    mem_access #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .operation  (operation),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .mem_data   (mem_data),
        .done       (done),
        .mem_err    (mem_err),
        .dmem       (dmem_bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        bit          we;
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mdata;
    } exp_t;

    exp_t        expq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] phys[256];
    logic [31:0] refm[256];
    logic [31:0] model_last;
    int          ack_delay;
    bit          resp_en;
    int          reqs_cur;
    bit          req_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Memory responder: ack after ack_delay wait cycles, rdata valid only in the ack cycle
    always @(posedge clk) begin
        static int cnt = 0;
        #1;
        if (!resp_en) begin
            cnt = 0;
        end else if (dmem_bus.dmem_req) begin
            if (cnt >= ack_delay) begin
                dmem_bus.dmem_ack = 1'b1;
                if (dmem_bus.dmem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (dmem_bus.dmem_be[b])
                            phys[dmem_bus.dmem_addr[9:2]][8*b +: 8] = dmem_bus.dmem_wdata[8*b +: 8];
                    dmem_bus.dmem_rdata = $urandom;
                end else begin
                    dmem_bus.dmem_rdata = phys[dmem_bus.dmem_addr[9:2]];
                end
                cnt = 0;
            end else begin
                dmem_bus.dmem_ack   = 1'b0;
                dmem_bus.dmem_rdata = $urandom;
                cnt++;
            end
        end else begin
            dmem_bus.dmem_ack   = 1'b0;
            dmem_bus.dmem_rdata = $urandom;
            cnt = 0;
        end
    end

    // Monitor: checks bus fields while a request is up, pops on done/mem_err
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (dmem_bus.dmem_req) begin
                if (!req_prev) reqs_cur++;
                if (expq.size() == 0) begin
                    fail_now("req_without_expected_access");
                end else begin
                    chk("dmem_addr", dmem_bus.dmem_addr, expq[0].waddr);
                    chk("dmem_we", 32'(dmem_bus.dmem_we), 32'(expq[0].we));
                    chk("dmem_be", 32'(dmem_bus.dmem_be), 32'(expq[0].be));
                    if (expq[0].we) chk("dmem_wdata", dmem_bus.dmem_wdata, expq[0].wdata);
                end
            end
            if (done || mem_err) begin
                if (expq.size() == 0) begin
                    fail_now("unexpected_done_or_err");
                end else begin
                    e = expq.pop_front();
                    chk("mem_err", 32'(mem_err), 32'(e.is_err));
                    chk("mem_data", mem_data, e.mdata);
                    chk("request_count", reqs_cur, e.is_err ? 0 : 1);
                end
                reqs_cur = 0;
            end
        end
        req_prev = dmem_bus.dmem_req;
    end

    // Reference model from the ISA rules, then drive and count stall cycles
    task automatic issue(input bit v, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input int delay);
        exp_t        e;
        int          k, size, n, exp_stall, idx;
        bit          load, memop, legal, ok;
        logic [63:0] w64, val;
        k     = int'(a[1:0]);
        idx   = int'(a[9:2]);
        load  = (opc == 7'b0000011);
        memop = v && (load || opc == 7'b0100011);
        legal = load ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ok    = legal && ((k % size) == 0);
        exp_stall = 0;
        if (memop) begin
            e.is_err = !ok;
            e.we     = !load;
            e.waddr  = a & 32'hFFFF_FFFC;
            e.be     = load ? 4'hF : 4'(((1 << size) - 1) << k);
            e.wdata  = (size == 1) ? sd[7:0] * 32'h0101_0101 :
                       (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
            e.mdata  = model_last;
            if (ok) begin
                exp_stall = 2 + delay;
                if (load) begin
                    w64        = {32'h0, refm[idx]};
                    val        = (w64 >> (8 * k)) & ((64'd1 << (8 * size)) - 64'd1);
                    e.mdata    = 32'(val << (32 - 8 * size));
                    model_last = e.mdata;
                end else begin
                    for (int i = 0; i < size; i++)
                        refm[idx][8*(k+i) +: 8] = sd[8*i +: 8];
                end
            end
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_in   = v;
        operation  = {2'($urandom), f3, opc};
        addr       = a;
        store_data = sd;
        ack_delay  = delay;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        chk("stall_cycles", n, exp_stall);
    endtask

    initial begin
        logic [6:0] opc;
        reset      = 1'b0;
        valid_in   = 1'b0;
        operation  = '0;
        addr       = '0;
        store_data = '0;
        resp_en    = 1'b1;
        ack_delay  = 0;
        reqs_cur   = 0;
        req_prev   = 1'b0;
        model_last = '0;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            phys[i] = $urandom;
            refm[i] = phys[i];
        end

        repeat (2) @(negedge clk);
        chk("reset_stall", 32'(stall), 0);
        chk("reset_req", 32'(dmem_bus.dmem_req), 0);
        chk("reset_we", 32'(dmem_bus.dmem_we), 0);
        chk("reset_addr", dmem_bus.dmem_addr, 0);
        chk("reset_be", 32'(dmem_bus.dmem_be), 0);
        chk("reset_wdata", dmem_bus.dmem_wdata, 0);
        chk("reset_mem_data", mem_data, 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_mem_err", 32'(mem_err), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        phys[8'h40] = 32'hDEAD_BEEF;
        refm[8'h40] = 32'hDEAD_BEEF;
        issue(1, OP_LOAD, F3_W, 32'h100, 32'h0, 0);
        phys[8'h40] = 32'h1122_3344;
        refm[8'h40] = 32'h1122_3344;
        issue(1, OP_LOAD, F3_B, 32'h103, 32'h0, 1);
        issue(1, OP_LOAD, F3_HU, 32'h102, 32'h0, 0);
        issue(1, OP_STORE, F3_H, 32'h206, 32'hCAFE_1234, 2);
        issue(1, OP_LOAD, F3_W, 32'h101, 32'h0, 0);
        issue(1, 7'b0110011, F3_B, 32'h104, 32'h0, 0);
        issue(1, OP_STORE, F3_B, 32'h011, 32'hA5A5_A57E, 0);
        issue(1, OP_LOAD, F3_W, 32'h010, 32'h0, 1);

        // Reset pulled during BUSY, then a stray ack after release
        resp_en = 1'b0;
        dmem_bus.dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        valid_in  = 1'b1;
        operation = {2'b00, F3_W, OP_LOAD};
        addr      = 32'h0000_0080;
        expq.push_back('{is_err: 1'b0, we: 1'b0, waddr: 32'h80, be: 4'hF, wdata: 32'h0, mdata: 32'h0});
        repeat (2) @(negedge clk);
        chk("busy_req_before_reset", 32'(dmem_bus.dmem_req), 1);
        #2 reset = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("req_async_reset", 32'(dmem_bus.dmem_req), 0);
        expq.delete();
        reqs_cur   = 0;
        model_last = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 dmem_bus.dmem_ack = 1'b1;
        @(posedge clk);
        #1 dmem_bus.dmem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("late_ack_done", 32'(done), 0);
            chk("late_ack_stall", 32'(stall), 0);
            chk("late_ack_req", 32'(dmem_bus.dmem_req), 0);
        end
        chk("mem_data_after_reset", mem_data, 0);
        resp_en = 1'b1;

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 4))
                0, 1:    opc = OP_LOAD;
                2, 3:    opc = OP_STORE;
                default: opc = 7'($urandom);
            endcase
            issue(($urandom_range(0, 7) != 0), opc, 3'($urandom),
                  {22'h0, 10'($urandom)}, $urandom, $urandom_range(0, 3));
        end

        @(posedge clk);
        #1 valid_in = 1'b0;
        for (int c = 0; c < 20 && expq.size() != 0; c++) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
